// File: rtl/mio_bus_arbiter.sv
// Two-requester arbiter for the single-port memory/peripheral bus.
// The CPU has fixed priority, and a starvation guard makes sure the display reader is still served.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | sample requests, latch the winner's command into mem_* regs
//  ACCESS | mem_en strobe for one cycle, latency counter loaded
//  WAIT   | count down the remaining memory latency
//  DONE   | mem_rdata valid; capture it into the winner's rdata register
//  ACK    | one-cycle completion pulse to the winner
module mio_bus_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int LAT    = 2,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [2:0]    cpu_ctrl,
    output logic [DW-1:0] cpu_rdata,
    output logic          MIO_ready,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_ctrl,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    grant_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        ACK    = 3'd4
    } state_t;

    localparam logic [3:0] LAT_M1     = 4'(LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE);
    localparam bit         ONE_CYCLE  = (LAT == 1);
    localparam logic [1:0] G_NONE     = 2'b00;
    localparam logic [1:0] G_CPU      = 2'b01;
    localparam logic [1:0] G_VID      = 2'b10;
    localparam logic [2:0] CTRL_FULL  = 3'b000;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       we_q;
    logic       pick_cpu;
    logic       pick_vid;

    // The display wins a contested IDLE sample only once the CPU has used its quota.
    always_comb begin
        state_nxt = state;
        pick_cpu  = 1'b0;
        pick_vid  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && !(vid_req && starve_cnt == STARVE_MAX)) begin
                    pick_cpu  = 1'b1;
                    state_nxt = ACCESS;
                end else if (vid_req) begin
                    pick_vid  = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = ONE_CYCLE ? DONE : WAIT;
            WAIT:    if (lat_cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            we_q       <= 1'b0;
            grant_out  <= G_NONE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_ctrl   <= 3'b000;
            cpu_rdata  <= '0;
            vid_rdata  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (!vid_req) starve_cnt <= 4'd0;
                    if (pick_cpu) begin
                        grant_out <= G_CPU;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_ctrl  <= cpu_ctrl;
                        we_q      <= cpu_we;
                        if (vid_req && starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (pick_vid) begin
                        // mem_wdata is left alone: the display never writes.
                        grant_out  <= G_VID;
                        mem_addr   <= vid_addr;
                        mem_ctrl   <= CTRL_FULL;
                        we_q       <= 1'b0;
                        starve_cnt <= 4'd0;
                    end
                end
                ACCESS: lat_cnt <= LAT_M1;
                WAIT:   lat_cnt <= lat_cnt - 4'd1;
                DONE: begin
                    if (!we_q) begin
                        if (grant_out == G_CPU) cpu_rdata <= mem_rdata;
                        else                    vid_rdata <= mem_rdata;
                    end
                end
                ACK:     grant_out <= G_NONE;
                default: grant_out <= G_NONE;
            endcase
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_we    = (state == ACCESS) && we_q;
    assign busy      = (state != IDLE);
    assign MIO_ready = (state == ACK) && (grant_out == G_CPU);
    assign vid_ack   = (state == ACK) && (grant_out == G_VID);

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: directed cases plus random CPU/display traffic,
// checked every cycle against a transaction-level timeline model.
module tb_mio_bus_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int LAT    = 2;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, vid_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [2:0]    cpu_ctrl = 3'b000;
    logic          vid_req = 1'b0;
    logic [DW-1:0] cpu_rdata, vid_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mio_ready, vid_ack, mem_en, mem_we, busy;
    logic [2:0]    mem_ctrl;
    logic [1:0]    grant_out;

    mio_bus_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ctrl(cpu_ctrl), .cpu_rdata(cpu_rdata), .MIO_ready(mio_ready),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata), .busy(busy), .grant_out(grant_out)
    );

    // Second instance built with single-cycle memory latency.
    logic          cpu_req_b = 1'b0;
    logic [AW-1:0] cpu_addr_b = '0;
    logic [DW-1:0] cpu_rdata_b, vid_rdata_b, mem_wdata_b, mem_rdata_b;
    logic [AW-1:0] mem_addr_b;
    logic          mio_ready_b, vid_ack_b, mem_en_b, mem_we_b, busy_b;
    logic [2:0]    mem_ctrl_b;
    logic [1:0]    grant_out_b;

    mio_bus_arbiter #(.AW(AW), .DW(DW), .LAT(1), .STARVE(STARVE)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req_b), .cpu_we(1'b0), .cpu_addr(cpu_addr_b), .cpu_wdata(32'h0),
        .cpu_ctrl(3'b000), .cpu_rdata(cpu_rdata_b), .MIO_ready(mio_ready_b),
        .vid_req(1'b0), .vid_addr(32'h0), .vid_rdata(vid_rdata_b), .vid_ack(vid_ack_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ctrl(mem_ctrl_b), .mem_rdata(mem_rdata_b), .busy(busy_b), .grant_out(grant_out_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory environment: fixed latency, junk on mem_rdata outside the valid cycle.
    logic [31:0] mem_arr [16];
    logic        pv0 = 1'b0, pv1 = 1'b0, pv_b = 1'b0;
    logic [31:0] pd0 = '0, pd1 = '0, pd_b = '0, junk = '0;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem_arr[mem_addr[5:2]] <= mem_wdata;
        pv0  <= mem_en && !mem_we;
        pd0  <= mem_arr[mem_addr[5:2]];
        pv1  <= pv0;
        pd1  <= pd0;
        pv_b <= mem_en_b && !mem_we_b;
        pd_b <= 32'hCAFE_0000 | mem_addr_b;
        junk <= $urandom;
    end
    assign mem_rdata   = pv1  ? pd1  : junk;
    assign mem_rdata_b = pv_b ? pd_b : ~junk;

    // Reference model: per grant, the cycles of the strobe and the ack, and the expected registers.
    int          cyc = 0;
    int          acc_c = -100, ack_c = -100, free_c = 0;
    int          starve = 0;
    logic [1:0]  m_g = 2'b00;
    logic        m_we = 1'b0;
    logic [31:0] m_rd = '0, m_wdata = '0, e_addr = '0, e_cpu_rd = '0, e_vid_rd = '0;
    logic [2:0]  e_ctrl = 3'b000;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                acc_c = -100; ack_c = -100; free_c = cyc + 1;
                starve = 0; m_g = 2'b00; m_we = 1'b0;
                e_addr = '0; e_ctrl = 3'b000; e_cpu_rd = '0; e_vid_rd = '0;
            end else begin
                if (cyc == ack_c - 1 && !m_we) begin
                    if (m_g == 2'b01) e_cpu_rd = m_rd;
                    else              e_vid_rd = m_rd;
                end
                if (cyc >= free_c) begin
                    if (!vid_req) starve = 0;
                    if (cpu_req || vid_req) begin
                        if (vid_req && (!cpu_req || starve == STARVE)) begin
                            m_g = 2'b10; starve = 0;
                            e_addr = vid_addr; e_ctrl = 3'b000; m_we = 1'b0;
                        end else begin
                            m_g = 2'b01;
                            if (vid_req && starve < STARVE) starve++;
                            e_addr = cpu_addr; e_ctrl = cpu_ctrl;
                            m_we = cpu_we; m_wdata = cpu_wdata;
                        end
                        m_rd   = mem_arr[e_addr[5:2]];
                        acc_c  = cyc + 1;
                        ack_c  = cyc + LAT + 2;
                        free_c = cyc + LAT + 3;
                    end
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            begin
                automatic bit in_txn = (cyc >= acc_c) && (cyc <= ack_c);
                check_eq("mem_en",    mem_en,    cyc == acc_c);
                check_eq("mem_we",    mem_we,    (cyc == acc_c) && m_we);
                check_eq("busy",      busy,      in_txn);
                check_eq("grant_out", grant_out, in_txn ? m_g : 2'b00);
                check_eq("MIO_ready", mio_ready, (cyc == ack_c) && (m_g == 2'b01));
                check_eq("vid_ack",   vid_ack,   (cyc == ack_c) && (m_g == 2'b10));
                check_eq("cpu_rdata", cpu_rdata, e_cpu_rd);
                check_eq("vid_rdata", vid_rdata, e_vid_rd);
                check_eq("mem_addr",  mem_addr,  e_addr);
                check_eq("mem_ctrl",  mem_ctrl,  e_ctrl);
                if (cyc == acc_c && m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
            end
        end
    end

    task automatic cpu_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] ct);
        int n;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_ctrl = ct;
        n = 0;
        do begin @(negedge clk); n++; end while (!mio_ready && n < 100);
        if (!mio_ready) check_eq("cpu_ack_timeout", mio_ready, 1'b1);
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    task automatic vid_txn(input logic [31:0] a);
        int n;
        @(negedge clk);
        vid_req = 1'b1; vid_addr = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!vid_ack && n < 100);
        if (!vid_ack) check_eq("vid_ack_timeout", vid_ack, 1'b1);
        @(posedge clk);
        #1 vid_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
        mem_arr[4]  = 32'hDEAD_BEEF;
        mem_arr[12] = 32'h0BAD_F00D;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_rd",   cpu_rdata, 32'h0);

        // CPU read, CPU write, then a same-edge contest
        cpu_txn(1'b0, 32'h10, 32'h0, 3'b000);
        check_eq("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cpu_txn(1'b1, 32'h20, 32'h1234_5678, 3'b000);
        check_eq("t2_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
        fork
            cpu_txn(1'b0, 32'h20, 32'h0, 3'b010);
            vid_txn(32'h30);
        join
        check_eq("t3_cpu_rd", cpu_rdata, 32'h1234_5678);
        check_eq("t3_vid_rd", vid_rdata, 32'h0BAD_F00D);

        // both held: the display gets every fifth slot
        fork
            begin
                for (int i = 0; i < 6; i++) cpu_txn(1'b0, 32'(i) << 2, 32'h0, 3'b001);
            end
            vid_txn(32'h3C);
        join

        // display request withdrawn right after its grant still completes
        @(negedge clk); vid_req = 1'b1; vid_addr = 32'h08;
        @(negedge clk); vid_req = 1'b0;
        repeat (6) @(negedge clk);

        // reset in WAIT aborts the transaction
        @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        check_eq("t5_busy",   busy, 1'b0);
        check_eq("t5_grant",  grant_out, 2'b00);
        check_eq("t5_cpu_rd", cpu_rdata, 32'h0);
        check_eq("t5_vid_rd", vid_rdata, 32'h0);
        repeat (6) @(negedge clk);

        // random mixed traffic
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    cpu_txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                            $urandom, 3'($urandom_range(0, 7)));
                end
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    vid_txn(32'($urandom_range(0, 15)) << 2);
                end
            end
        join

        // single-cycle latency build: DONE in cycle 2, ack in cycle 3
        @(negedge clk); cpu_req_b = 1'b1; cpu_addr_b = 32'h44;
        @(negedge clk);
        check_eq("l1_c1_en",  mem_en_b, 1'b1);
        @(negedge clk);
        check_eq("l1_c2_en",  mem_en_b, 1'b0);
        check_eq("l1_c2_rdy", mio_ready_b, 1'b0);
        check_eq("l1_c2_grant", grant_out_b, 2'b01);
        @(negedge clk);
        check_eq("l1_c3_rdy", mio_ready_b, 1'b1);
        check_eq("l1_c3_rd",  cpu_rdata_b, 32'hCAFE_0044);
        check_eq("l1_vid_rd", vid_rdata_b, 32'h0);
        @(posedge clk); #1 cpu_req_b = 1'b0;
        @(negedge clk);
        check_eq("l1_idle", busy_b, 1'b0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
